// File: rtl/dma_backend_arbiter.sv
// rtl/dma_backend_arbiter.sv - round-robin sharing of one DMA backend among NumReq frontends
// Owner indices of in-flight jobs are queued in issue order so completions route back.
module dma_backend_arbiter #(
    parameter int unsigned NumReq         = 4,
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned LenWidth       = 32,
    parameter int unsigned MaxOutstanding = 8
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [NumReq*AddrWidth-1:0]          req_src_addr_i,
    input  logic [NumReq*AddrWidth-1:0]          req_dst_addr_i,
    input  logic [NumReq*LenWidth-1:0]           req_num_bytes_i,
    input  logic [NumReq-1:0]                    req_valid_i,
    output logic [NumReq-1:0]                    req_ready_o,
    output logic [NumReq-1:0]                    req_done_o,
    output logic [NumReq-1:0]                    req_busy_o,
    output logic [AddrWidth-1:0]                 dm_src_addr_o,
    output logic [AddrWidth-1:0]                 dm_dst_addr_o,
    output logic [LenWidth-1:0]                  dm_num_bytes_o,
    output logic                                 dm_valid_o,
    input  logic                                 dm_ready_i,
    input  logic                                 dm_trans_complete_i,
    output logic [$clog2(MaxOutstanding+1)-1:0]  outstanding_o,
    output logic                                 idle_o
);
    localparam int unsigned IdxW = $clog2(NumReq);
    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
    localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

    logic [IdxW-1:0] r_ptr;
    logic            r_lock;
    logic [IdxW-1:0] r_lock_idx;
    logic [IdxW-1:0] r_fifo [MaxOutstanding];
    logic [PtrW-1:0] r_wr;
    logic [PtrW-1:0] r_rd;
    logic [CntW-1:0] r_count;
    logic [CntW-1:0] r_cnt [NumReq];
    logic [NumReq-1:0] r_done;

    logic [IdxW-1:0] w_win;
    logic [IdxW-1:0] w_head;
    logic [IdxW:0]   w_sum;
    logic            w_found;
    logic            w_any;
    logic            w_full;
    logic            w_hs;
    logic            w_pop;
    logic [NumReq-1:0] w_inc;
    logic [NumReq-1:0] w_dec;

    assign w_full = (r_count == CntW'(MaxOutstanding));
    assign w_head = r_fifo[r_rd];

    // A stalled grant stays with its requester; otherwise search from the RR pointer.
    always_comb begin
        w_win   = '0;
        w_found = 1'b0;
        w_sum   = '0;
        w_any   = 1'b0;
        if (r_lock) begin
            w_win = r_lock_idx;
            w_any = req_valid_i[r_lock_idx];
        end else begin
            w_any = |req_valid_i;
            for (int k = 0; k < NumReq; k++) begin
                w_sum = {1'b0, r_ptr} + (IdxW+1)'(k);
                if (w_sum >= (IdxW+1)'(NumReq)) begin
                    w_sum = w_sum - (IdxW+1)'(NumReq);
                end
                if (!w_found && req_valid_i[w_sum[IdxW-1:0]]) begin
                    w_found = 1'b1;
                    w_win   = w_sum[IdxW-1:0];
                end
            end
        end
    end

    assign dm_valid_o     = w_any & ~w_full;
    assign dm_src_addr_o  = req_src_addr_i[w_win*AddrWidth +: AddrWidth];
    assign dm_dst_addr_o  = req_dst_addr_i[w_win*AddrWidth +: AddrWidth];
    assign dm_num_bytes_o = req_num_bytes_i[w_win*LenWidth +: LenWidth];
    assign w_hs           = dm_valid_o & dm_ready_i;
    assign w_pop          = dm_trans_complete_i & (r_count != '0);
    assign req_ready_o    = w_hs ? (NumReq'(1) << w_win) : '0;
    assign req_done_o     = r_done;
    assign outstanding_o  = r_count;
    assign idle_o         = (r_count == '0) & ~dm_valid_o;

    always_comb begin
        w_inc      = '0;
        w_dec      = '0;
        req_busy_o = '0;
        for (int i = 0; i < NumReq; i++) begin
            w_inc[i]      = w_hs & (w_win == IdxW'(i));
            w_dec[i]      = w_pop & (w_head == IdxW'(i));
            req_busy_o[i] = (r_cnt[i] != '0);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ptr      <= '0;
            r_lock     <= 1'b0;
            r_lock_idx <= '0;
            r_wr       <= '0;
            r_rd       <= '0;
            r_count    <= '0;
            r_done     <= '0;
            for (int i = 0; i < NumReq; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_done <= w_pop ? (NumReq'(1) << w_head) : '0;
            if (w_hs) begin
                r_lock <= 1'b0;
                r_ptr  <= (w_win == IdxW'(NumReq - 1)) ? '0 : w_win + 1'b1;
                r_wr   <= (r_wr == PtrW'(MaxOutstanding - 1)) ? '0 : r_wr + 1'b1;
            end else if (dm_valid_o) begin
                r_lock     <= 1'b1;
                r_lock_idx <= w_win;
            end
            if (w_pop) begin
                r_rd <= (r_rd == PtrW'(MaxOutstanding - 1)) ? '0 : r_rd + 1'b1;
            end
            if (w_hs && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_hs && w_pop) begin
                r_count <= r_count - 1'b1;
            end
            for (int i = 0; i < NumReq; i++) begin
                if (w_inc[i] && !w_dec[i]) begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end else if (!w_inc[i] && w_dec[i]) begin
                    r_cnt[i] <= r_cnt[i] - 1'b1;
                end
            end
        end
    end

    // Owner storage carries no control meaning while empty, so it needs no reset.
    always_ff @(posedge clk_i) begin
        if (w_hs) begin
            r_fifo[r_wr] <= w_win;
        end
    end

    a_pending_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        r_lock |-> (req_valid_i[r_lock_idx] && $stable(dm_src_addr_o) &&
                    $stable(dm_dst_addr_o) && $stable(dm_num_bytes_o)));

    a_complete_nonempty: assert property (@(posedge clk_i) disable iff (!rst_ni)
        dm_trans_complete_i |-> (r_count != '0))
        else $warning("completion pulse with no job outstanding ignored");

endmodule
